// File: rtl/uart_rx_word_packer.sv
// ---------------------------------------------------------------------------
// uart_rx_word_packer
//
// Collects bytes from a UART receiver into little-endian 32-bit words and
// queues the completed words in a small FIFO. A two-state read FSM pops
// words on request from the Interpreter.
//
// Ports
//   clk             : single system clock, rising edge
//   rst             : synchronous active-high reset
//   rx_byte_valid_i : one-cycle strobe of a received byte
//   rx_byte_i       : received byte, meaningful only with the strobe
//   rx_frame_err_i  : marks the current strobe as a framing error
//   read            : word-read request pulse
//   read_response   : one-cycle completion pulse for an accepted read
//   read_data       : most recently popped word
//   uart_rx_empty   : high while the FIFO holds no complete word
//   level_o         : FIFO occupancy in words
//   overflow_o      : sticky, a completed word was dropped on a full FIFO
//   frame_err_o     : sticky, a byte arrived with a framing error
// ---------------------------------------------------------------------------
module uart_rx_word_packer #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int BIT_RATE      = 9600,
  parameter int WORD_SIZE_BY  = 4,
  parameter int BUFFER_SIZE   = 8,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx_byte_valid_i,
  input  logic [7:0]                     rx_byte_i,
  input  logic                           rx_frame_err_i,
  input  logic                           read,
  output logic                           read_response,
  output logic [31:0]                    read_data,
  output logic                           uart_rx_empty,
  output logic [$clog2(BUFFER_SIZE):0]   level_o,
  output logic                           overflow_o,
  output logic                           frame_err_o
);

  localparam int AW             = $clog2(BUFFER_SIZE);
  localparam int LW             = AW + 1;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BIT_RATE);
  localparam int GW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]    LAST_IDX  = 2'(WORD_SIZE_BY - 1);
  localparam logic [GW-1:0] GAP_LIMIT = GW'(TIMEOUT_CYCLES);
  localparam logic [LW-1:0] FULL_LVL  = LW'(BUFFER_SIZE);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } readState_t;

  readState_t      r_state;
  logic [1:0]      r_byteCnt;
  logic [23:0]     r_partial;
  logic [GW-1:0]   r_gap;
  logic [31:0]     r_mem [BUFFER_SIZE];
  logic [AW-1:0]   r_wrPtr;
  logic [AW-1:0]   r_rdPtr;
  logic [LW-1:0]   r_level;
  logic            r_empty;
  logic            r_overflow;
  logic            r_frameErr;
  logic            r_resp;
  logic [31:0]     r_data;

  logic            w_goodStrobe;
  logic            w_badStrobe;
  logic            w_wordDone;
  logic [31:0]     w_word;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [LW-1:0]   w_levelNext;

  assign w_goodStrobe = rx_byte_valid_i & ~rx_frame_err_i;
  assign w_badStrobe  = rx_byte_valid_i &  rx_frame_err_i;
  assign w_wordDone   = w_goodStrobe && (r_byteCnt == LAST_IDX);
  // The final byte bypasses the partial register straight into the word.
  assign w_word       = {rx_byte_i, r_partial};
  assign w_full       = (r_level == FULL_LVL);
  assign w_pop        = (r_state == S_IDLE) && read && !r_empty;
  // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
  assign w_push       = w_wordDone && (!w_full || w_pop);
  assign w_drop       = w_wordDone && w_full && !w_pop;

  always_comb begin
    w_levelNext = r_level;
    case ({w_push, w_pop})
      2'b10:   w_levelNext = r_level + LW'(1);
      2'b01:   w_levelNext = r_level - LW'(1);
      default: w_levelNext = r_level;
    endcase
  end

  // Byte assembly. The counter wraps naturally after the last byte, which
  // also covers the dropped-word case. The gap timer only runs while a
  // partial word exists; hitting the limit silently abandons it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byteCnt <= 2'd0;
      r_partial <= 24'd0;
      r_gap     <= '0;
    end else if (w_badStrobe) begin
      r_byteCnt <= 2'd0;
      r_gap     <= '0;
    end else if (w_goodStrobe) begin
      r_byteCnt <= r_byteCnt + 2'd1;
      r_gap     <= '0;
      case (r_byteCnt)
        2'd0:    r_partial[7:0]   <= rx_byte_i;
        2'd1:    r_partial[15:8]  <= rx_byte_i;
        2'd2:    r_partial[23:16] <= rx_byte_i;
        default: r_partial        <= r_partial;
      endcase
    end else if (r_byteCnt != 2'd0) begin
      if (r_gap == GAP_LIMIT) begin
        r_byteCnt <= 2'd0;
        r_gap     <= '0;
      end else begin
        r_gap <= r_gap + GW'(1);
      end
    end else begin
      r_gap <= '0;
    end
  end

  // Word storage carries no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_word;
    end
  end

  // FIFO bookkeeping and sticky status flags. Pointers wrap on their own
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_level <= w_levelNext;
      r_empty <= (w_levelNext == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_badStrobe) begin
        r_frameErr <= 1'b1;
      end
    end
  end

  // Read FSM. The head word is captured as it is popped, so the response
  // pulse in S_RESP presents data already settled; read is ignored there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_resp  <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_resp <= 1'b0;
          if (w_pop) begin
            r_data  <= r_mem[r_rdPtr];
            r_resp  <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_resp  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_response = r_resp;
  assign read_data     = r_data;
  assign uart_rx_empty = r_empty;
  assign level_o       = r_level;
  assign overflow_o    = r_overflow;
  assign frame_err_o   = r_frameErr;

endmodule
